pqvalue_bfly_pipe: RTL and testbench

Pipelined, multi-lane NTT butterfly with valid/ready handshaking, supporting Cooley-Tukey and Gentleman-Sande butterflies under Dilithium (q = 8380417) or Kyber (q = 3329) moduli. It is the parametrised successor of the single-cycle butterfly datapath, for NTT/INTT sequencers that need throughput of one butterfly per lane per cycle at a higher clock rate. Mode and modulus are carried per beat, so consecutive transactions may differ. It sits between the coefficient-memory read port and the write-back path of the PQ accelerator.

---
 rtl/pqvalue_bfly_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_pqvalue_bfly_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pqvalue_bfly_pipe.sv
// Pipelined multi-lane NTT butterfly (CT/GS, Dilithium/Kyber) with valid/ready handshaking.
// Optional feature macro: PQV_BFLY_HALVE_EN enables multiplying GS results by 2^-1 mod q when halve_i is set.
module pqvalue_bfly_pipe #(
    parameter int LANES  = 2,
    parameter int STAGES = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [LANES*23-1:0]  a_i,
    input  logic [LANES*23-1:0]  b_i,
    input  logic [LANES*23-1:0]  twiddle_i,
    input  logic                 sel_red_i,
    input  logic                 sel_butterfly_i,
    input  logic                 halve_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [LANES*23-1:0]  a_o,
    output logic [LANES*23-1:0]  b_o,
    output logic                 busy_o,
    output logic [31:0]          ops_cnt_o
);

    typedef struct packed {
        logic [LANES*23-1:0] a;
        logic [LANES*23-1:0] b;
        logic [LANES*23-1:0] w;
        logic                red;
        logic                gs;
        logic                hv;
    } beat_t;

    function automatic logic [23:0] modulus(input logic red);
        return red ? 24'd3329 : 24'd8380417;
    endfunction

    function automatic logic [22:0] mod_add(input logic [22:0] x, input logic [22:0] y, input logic red);
        logic [23:0] q;
        logic [23:0] sum;
        q   = modulus(red);
        sum = {1'b0, x} + {1'b0, y};
        return (sum >= q) ? 23'(sum - q) : sum[22:0];
    endfunction

    function automatic logic [22:0] mod_sub(input logic [22:0] x, input logic [22:0] y, input logic red);
        logic [23:0] q;
        q = modulus(red);
        return (x >= y) ? (x - y) : 23'({1'b0, x} + q - {1'b0, y});
    endfunction

    // Exact 46-bit product, then full reduction by whichever modulus the beat carries.
    function automatic logic [22:0] mod_mul(input logic [22:0] x, input logic [22:0] y, input logic red);
        logic [45:0] p;
        p = {23'd0, x} * {23'd0, y};
        return red ? 23'(p % 46'd3329) : 23'(p % 46'd8380417);
    endfunction

    // First half of the butterfly: CT forms t = w*b (kept in b), GS forms a+b and a-b.
    function automatic beat_t phase_a(input beat_t x);
        beat_t y;
        y = x;
        for (int k = 0; k < LANES; k++) begin
            if (x.gs) begin
                y.a[23*k +: 23] = mod_add(x.a[23*k +: 23], x.b[23*k +: 23], x.red);
                y.b[23*k +: 23] = mod_sub(x.a[23*k +: 23], x.b[23*k +: 23], x.red);
            end else begin
                y.b[23*k +: 23] = mod_mul(x.w[23*k +: 23], x.b[23*k +: 23], x.red);
            end
        end
        return y;
    endfunction

    // Second half: CT adds/subtracts t, GS scales the difference by w.
    function automatic beat_t phase_b(input beat_t x);
        beat_t y;
        y = x;
        for (int k = 0; k < LANES; k++) begin
            if (x.gs) begin
                y.b[23*k +: 23] = mod_mul(x.b[23*k +: 23], x.w[23*k +: 23], x.red);
            end else begin
                y.a[23*k +: 23] = mod_add(x.a[23*k +: 23], x.b[23*k +: 23], x.red);
                y.b[23*k +: 23] = mod_sub(x.a[23*k +: 23], x.b[23*k +: 23], x.red);
            end
        end
        return y;
    endfunction

`ifdef PQV_BFLY_HALVE_EN
    function automatic logic [22:0] halve(input logic [22:0] x, input logic red);
        return x[0] ? 23'(({1'b0, x} + modulus(red)) >> 1) : {1'b0, x[22:1]};
    endfunction

    function automatic beat_t phase_h(input beat_t x);
        beat_t y;
        y = x;
        if (x.gs && x.hv) begin
            for (int k = 0; k < LANES; k++) begin
                y.a[23*k +: 23] = halve(x.a[23*k +: 23], x.red);
                y.b[23*k +: 23] = halve(x.b[23*k +: 23], x.red);
            end
        end
        return y;
    endfunction
`else
    function automatic beat_t phase_h(input beat_t x);
        return x;
    endfunction
`endif

    beat_t             in_beat;
    beat_t             after_a;
    beat_t             after_b;
    beat_t             after_h;
    beat_t             pb_in;
    beat_t             ph_in;
    beat_t             load_d [STAGES];
    beat_t             data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] stage_ready;
    logic [STAGES-1:0] stage_in_valid;
    logic              ready_chain;
    logic [31:0]       ops_cnt_q;
    logic              unused_tail;

    assign in_beat.a   = a_i;
    assign in_beat.b   = b_i;
    assign in_beat.w   = twiddle_i;
    assign in_beat.red = sel_red_i;
    assign in_beat.gs  = sel_butterfly_i;
`ifdef PQV_BFLY_HALVE_EN
    assign in_beat.hv  = halve_i;
`else
    logic unused_halve;
    assign in_beat.hv   = 1'b0;
    assign unused_halve = halve_i;
`endif

    assign after_a = phase_a(in_beat);
    assign after_b = phase_b(pb_in);
    assign after_h = phase_h(ph_in);

    // Phase placement: multiplier and add/sub always land in different stages once STAGES >= 3.
    if (STAGES == 1) begin : g_one
        assign pb_in     = after_a;
        assign ph_in     = after_b;
        assign load_d[0] = after_h;
    end else if (STAGES == 2) begin : g_two
        assign pb_in     = data_q[0];
        assign ph_in     = after_b;
        assign load_d[0] = after_a;
        assign load_d[1] = after_h;
    end else begin : g_deep
        assign pb_in     = data_q[0];
        assign ph_in     = data_q[1];
        assign load_d[0] = after_a;
        assign load_d[1] = after_b;
        assign load_d[2] = after_h;
        for (genvar s = 3; s < STAGES; s++) begin : g_pass
            assign load_d[s] = data_q[s-1];
        end
    end

    // A stage can take a new beat if it is empty or every stage after it is moving.
    always_comb begin
        ready_chain = out_ready_i;
        stage_ready = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            ready_chain    = ready_chain || !valid_q[s];
            stage_ready[s] = ready_chain;
        end
    end

    always_comb begin
        stage_in_valid    = '0;
        stage_in_valid[0] = in_valid_i;
        for (int s = 1; s < STAGES; s++) begin
            stage_in_valid[s] = valid_q[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (stage_ready[s]) begin
                    valid_q[s] <= stage_in_valid[s];
                    if (stage_in_valid[s]) begin
                        data_q[s] <= load_d[s];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ops_cnt_q <= '0;
        end else if (in_valid_i && stage_ready[0]) begin
            ops_cnt_q <= ops_cnt_q + 32'd1;
        end
    end

    assign in_ready_o  = stage_ready[0];
    assign out_valid_o = valid_q[STAGES-1];
    assign a_o         = data_q[STAGES-1].a;
    assign b_o         = data_q[STAGES-1].b;
    assign busy_o      = |valid_q;
    assign ops_cnt_o   = ops_cnt_q;
    assign unused_tail = ^{data_q[STAGES-1].w, data_q[STAGES-1].red, data_q[STAGES-1].gs, data_q[STAGES-1].hv};

endmodule

// File: tb/tb_pqvalue_bfly_pipe.sv
// Scoreboard bench for pqvalue_bfly_pipe: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_pqvalue_bfly_pipe;
    localparam int LANES  = 2;
    localparam int STAGES = 3;
    localparam int W      = LANES * 23;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic [W-1:0]   twiddle_i;
    logic           sel_red_i;
    logic           sel_butterfly_i;
    logic           halve_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [W-1:0]   a_o;
    logic [W-1:0]   b_o;
    logic           busy_o;
    logic [31:0]    ops_cnt_o;

    int             n_cmp  = 0;
    int             n_fail = 0;
    logic [2*W-1:0] exp_q[$];
    int             inflight   = 0;
    logic           stall_prev = 1'b0;
    logic [2*W-1:0] held;
    logic           rand_ready = 1'b0;

    pqvalue_bfly_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .twiddle_i(twiddle_i), .sel_red_i(sel_red_i),
        .sel_butterfly_i(sel_butterfly_i), .halve_i(halve_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .a_o(a_o), .b_o(b_o), .busy_o(busy_o), .ops_cnt_o(ops_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [2*W-1:0] pack2(input int a1, input int a0, input int b1, input int b0);
        return {23'(a1), 23'(a0), 23'(b1), 23'(b0)};
    endfunction

    // Golden model in plain 64-bit arithmetic, independent of the RTL structure.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] w, input logic red,
                                             input logic gs, input logic hv);
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        longint q, x, y, z, t, pa, pb;
        q = red ? 64'd3329 : 64'd8380417;
        for (int k = 0; k < LANES; k++) begin
            x = {41'd0, a[23*k +: 23]};
            y = {41'd0, b[23*k +: 23]};
            z = {41'd0, w[23*k +: 23]};
            if (!gs) begin
                t  = (z * y) % q;
                pa = (x + t) % q;
                pb = (x - t + q) % q;
            end else begin
                pa = (x + y) % q;
                pb = (((x - y + q) % q) * z) % q;
`ifdef PQV_BFLY_HALVE_EN
                if (hv) begin
                    pa = (pa % 2 == 0) ? pa / 2 : (pa + q) / 2;
                    pb = (pb % 2 == 0) ? pb / 2 : (pb + q) / 2;
                end
`endif
            end
            ra[23*k +: 23] = 23'(pa);
            rb[23*k +: 23] = 23'(pb);
        end
        if (hv === 1'bx) ra = '0;
        return {ra, rb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_stimulus(input int a0, input int b0, input int w0,
                                  input int a1, input int b1, input int w1,
                                  input logic red, input logic gs, input logic hv,
                                  input logic [2*W-1:0] exp);
        int cyc;
        a_i             = {23'(a1), 23'(a0)};
        b_i             = {23'(b1), 23'(b0)};
        twiddle_i       = {23'(w1), 23'(w0)};
        sel_red_i       = red;
        sel_butterfly_i = gs;
        halve_i         = hv;
        in_valid_i      = 1'b1;
        cyc             = 0;
        forever begin
            @(negedge clk);
            if (in_ready_o) begin
                exp_q.push_back(exp);
                step();
                break;
            end
            step();
            cyc++;
            if (cyc > 300) begin
                report_timeout("accept");
                in_valid_i = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        int cyc;
        in_valid_i = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0) begin
            step();
            cyc++;
            if (cyc > 500) begin
                report_timeout("drain");
                break;
            end
        end
    endtask

    // Monitor: scoreboard pops, stall stability, and in_ready versus tracked occupancy.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            inflight   = 0;
            stall_prev = 1'b0;
        end else begin
            check("in_ready", in_ready_o, !(inflight == STAGES && !out_ready_i));
            if (stall_prev) begin
                check("stall_valid", out_valid_o, 1'b1);
                check("stall_hold", {a_o, b_o}, held);
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: got %0h expected none", {a_o, b_o});
                end else begin
                    check("result", {a_o, b_o}, exp_q.pop_front());
                end
            end
            stall_prev = out_valid_o && !out_ready_i;
            held       = {a_o, b_o};
            inflight   = inflight + int'(in_valid_i && in_ready_o) - int'(out_valid_o && out_ready_i);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output_reset(input string tag);
        check({tag, "_out_valid"}, out_valid_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_ops_cnt"}, ops_cnt_o, 32'd0);
        check({tag, "_a_o"}, a_o, '0);
        check({tag, "_b_o"}, b_o, '0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rw;
        logic         rr, rg, rh;
        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        a_i = '0; b_i = '0; twiddle_i = '0;
        sel_red_i = 1'b0; sel_butterfly_i = 1'b0; halve_i = 1'b0;
        step();
        step();
        @(negedge clk);
        check_output_reset("reset");
        step();
        rst_ni = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready_o, 1'b1);
        step();

        // Kyber CT, then latency and counter
        apply_stimulus(1, 2, 3, 100, 200, 10, 1'b1, 1'b0, 1'b0, pack2(2100, 7, 1429, 3324));
        in_valid_i = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            @(negedge clk);
            check("latency_valid", out_valid_o, (k == STAGES - 1));
            if (k == 0) check("busy_in_flight", busy_o, 1'b1);
            step();
        end
        check("ops_cnt_one", ops_cnt_o, 32'd1);

        // Back-to-back per-beat mode switch
        apply_stimulus(5, 8, 2, 8380416, 1, 1, 1'b0, 1'b1, 1'b0, pack2(0, 13, 8380415, 8380411));
        apply_stimulus(3328, 1, 1, 0, 3328, 3328, 1'b1, 1'b0, 1'b0, pack2(1, 0, 3328, 3327));
        drain();

        // Halve requests (CT beat must ignore it)
`ifdef PQV_BFLY_HALVE_EN
        apply_stimulus(2, 1, 1, 10, 4, 2, 1'b1, 1'b1, 1'b1, pack2(7, 1666, 6, 1665));
        apply_stimulus(1, 2, 1, 0, 0, 5, 1'b0, 1'b1, 1'b1, pack2(0, 4190210, 0, 4190208));
`else
        apply_stimulus(2, 1, 1, 10, 4, 2, 1'b1, 1'b1, 1'b1, pack2(14, 3, 12, 1));
        apply_stimulus(1, 2, 1, 0, 0, 5, 1'b0, 1'b1, 1'b1, pack2(0, 3, 0, 8380416));
`endif
        apply_stimulus(1, 2, 3, 100, 200, 10, 1'b1, 1'b0, 1'b1, pack2(2100, 7, 1429, 3324));
        drain();

        // Fill under backpressure, confirm stall, then release
        out_ready_i = 1'b0;
        apply_stimulus(11, 7, 0, 1011, 9, 0, 1'b1, 1'b0, 1'b0, pack2(1011, 11, 1011, 11));
        apply_stimulus(22, 7, 0, 1022, 9, 0, 1'b1, 1'b0, 1'b0, pack2(1022, 22, 1022, 22));
        apply_stimulus(33, 7, 0, 1033, 9, 0, 1'b1, 1'b0, 1'b0, pack2(1033, 33, 1033, 33));
        in_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_in_ready", in_ready_o, 1'b0);
            check("full_busy", busy_o, 1'b1);
            step();
        end
        out_ready_i = 1'b1;
        apply_stimulus(8380416, 8380416, 8380416, 0, 1, 2, 1'b0, 1'b0, 1'b0, pack2(2, 0, 8380415, 8380415));
        drain();

        // Reset with a full pipeline discards everything in flight
        out_ready_i = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            apply_stimulus(5 + k, 0, 0, 6, 0, 0, 1'b1, 1'b0, 1'b0, pack2(6, 5 + k, 6, 5 + k));
        end
        in_valid_i = 1'b0;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        @(negedge clk);
        check_output_reset("midreset");
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            check("no_stale_valid", out_valid_o, 1'b0);
        end
        step();

        // Pseudo-random stream with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            rr = 1'($urandom_range(0, 1));
            rg = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            for (int k = 0; k < LANES; k++) begin
                ra[23*k +: 23] = 23'($urandom_range(0, rr ? 3328 : 8380416));
                rb[23*k +: 23] = 23'($urandom_range(0, rr ? 3328 : 8380416));
                rw[23*k +: 23] = 23'($urandom_range(0, rr ? 3328 : 8380416));
            end
            apply_stimulus(int'(ra[22:0]), int'(rb[22:0]), int'(rw[22:0]),
                           int'(ra[45:23]), int'(rb[45:23]), int'(rw[45:23]),
                           rr, rg, rh, model(ra, rb, rw, rr, rg, rh));
            if ($urandom_range(0, 3) == 0) begin
                in_valid_i = 1'b0;
                step();
            end
        end
        drain();
        rand_ready  = 1'b0;
        out_ready_i = 1'b1;
        check("ops_cnt_stream", ops_cnt_o, 32'd20);

        // Counter wrap from a preloaded value
        force dut.ops_cnt_q = 32'hFFFF_FFFE;
        step();
        release dut.ops_cnt_q;
        @(negedge clk);
        check("ops_cnt_preload", ops_cnt_o, 32'hFFFF_FFFE);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, pack2(0, 0, 0, 0));
        check("ops_cnt_max", ops_cnt_o, 32'hFFFF_FFFF);
        apply_stimulus(4, 1, 1, 4, 1, 1, 1'b1, 1'b0, 1'b0, pack2(5, 5, 3, 3));
        check("ops_cnt_wrap", ops_cnt_o, 32'd0);
        drain();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
